cbus_rr_arbiter: RTL and testbench

N-input round-robin arbiter for the core's cache bus (CBus), the next generation of the core's fixed-priority CBus arbiter. It multiplexes `NUM_INPUTS` requesters (I-fetch, D-access, page-table walker, and similar) onto one downstream CBus port feeding memory translation and memory. It adds starvation-free rotating priority, optional fixed priority, and early release when a requester withdraws. It holds a grant for a whole burst, until the downstream port signals the last beat.

---
 rtl/cbus_rr_arbiter_pkg.sv | 28 ++
 rtl/cbus_rr_pick.sv | 40 ++++
 rtl/cbus_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus types, arbiter state encoding and index-width helper for cbus_rr_arbiter.
package cbus_rr_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_t;

  // A single requester still needs a 1-bit index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_rr_pick.sv
// Combinational rotated priority encoder: first valid index at or after rr_ptr_i, wrapping.
module cbus_rr_pick
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter bit          RR_EN      = 1'b1
) (
  input  logic [NUM_INPUTS-1:0]            valid_i,
  input  logic [idx_width(NUM_INPUTS)-1:0] rr_ptr_i,
  output logic                             any_valid_o,
  output logic [idx_width(NUM_INPUTS)-1:0] win_o
);

  localparam int unsigned IdxW = idx_width(NUM_INPUTS);

  int unsigned     start;
  int unsigned     idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    any_valid_o = 1'b0;
    win_o       = '0;
    idx         = 0;
    cand        = '0;
    // Fixed priority is just a scan that always starts at index 0.
    start       = RR_EN ? 32'(rr_ptr_i) : 0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      idx = start + i;
      if (idx >= NUM_INPUTS) begin
        idx = idx - NUM_INPUTS;
      end
      cand = IdxW'(idx);
      if (!any_valid_o && valid_i[cand]) begin
        any_valid_o = 1'b1;
        win_o       = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-input round-robin / fixed-priority CBus arbiter holding each grant for a whole burst.
// Optional per-input saturating grant counters are built when CBUS_ARB_PERF_EN is defined.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter bit          RR_EN      = 1'b1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]          ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]          iresps,
  output cbus_req_t                            oreq,
  input  cbus_resp_t                           oresp,
`ifdef CBUS_ARB_PERF_EN
  output logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] grant_cnt,
`endif
  output logic [idx_width(NUM_INPUTS)-1:0]     grant_idx,
  output logic                                 busy
);

  localparam int unsigned IdxW    = idx_width(NUM_INPUTS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_INPUTS - 1);

  if (NUM_INPUTS < 1 || CNT_WIDTH < 1) begin : g_param_chk
    $error("cbus_rr_arbiter: NUM_INPUTS and CNT_WIDTH must be at least 1");
  end

  arb_state_t            state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       win;
  logic [NUM_INPUTS-1:0] valid_vec;
  logic                  any_valid;
  logic                  done;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_valid
    assign valid_vec[g] = ireqs[g].valid;
  end

  cbus_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .RR_EN      (RR_EN)
  ) u_pick (
    .valid_i     (valid_vec),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (any_valid),
    .win_o       (win)
  );

  assign done = oresp.ready && oresp.last;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d = StBusy;
          grant_d = win;
        end
      end
      StBusy: begin
        // Completion beats withdrawal so the finished owner drops to lowest priority.
        if (done) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + IdxW'(1);
        end else if (!ireqs[grant_q].valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Live pass-through so later burst beats carry the requester's current data/strobe.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == StBusy) begin
      oreq            = ireqs[grant_q];
      iresps[grant_q] = oresp;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == StBusy);

`ifdef CBUS_ARB_PERF_EN
  logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && any_valid && cnt_q[win] != '1) begin
      cnt_d[win] = cnt_q[win] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int unsigned N = 3;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  cbus_req_t  [N-1:0] ireqs;
  cbus_resp_t [N-1:0] iresps, iresps_fp;
  cbus_req_t          oreq, oreq_fp;
  cbus_resp_t         oresp;
  logic [1:0]         grant_idx, grant_idx_fp;
  logic               busy, busy_fp;
`ifdef CBUS_ARB_PERF_EN
  logic [N-1:0][3:0]  grant_cnt, grant_cnt_fp;
`endif

  int checks = 0;
  int errors = 0;
  int exp_rr[6] = '{0, 1, 2, 0, 1, 2};

  always #5 clk = ~clk;

  cbus_rr_arbiter #(
    .NUM_INPUTS (N),
    .RR_EN      (1'b1),
    .CNT_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
`ifdef CBUS_ARB_PERF_EN
    .grant_cnt (grant_cnt),
`endif
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  cbus_rr_arbiter #(
    .NUM_INPUTS (N),
    .RR_EN      (1'b0),
    .CNT_WIDTH  (4)
  ) dut_fp (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps_fp),
    .oreq      (oreq_fp),
    .oresp     (oresp),
`ifdef CBUS_ARB_PERF_EN
    .grant_cnt (grant_cnt_fp),
`endif
    .grant_idx (grant_idx_fp),
    .busy      (busy_fp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 8 && !busy; i++) step();
    chk({tag, " busy"}, 128'(busy), 128'(1));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    ireqs = '0;
    oresp = '0;
    #12;
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst grant_idx", 128'(grant_idx), 128'(0));
    chk("rst oreq", 128'(oreq), 128'(0));
    chk("rst iresps", 128'(iresps), 128'(0));
`ifdef CBUS_ARB_PERF_EN
    chk("rst grant_cnt", 128'(grant_cnt), 128'(0));
`endif
    reset = 1'b1;
    step();

    // Single read from input 1.
    ireqs[1].valid = 1'b1;
    ireqs[1].addr  = 32'h40;
    #1;
    chk("single idle oreq.valid", 128'(oreq.valid), 128'(0));
    step();
    chk("single oreq.valid", 128'(oreq.valid), 128'(1));
    chk("single grant_idx", 128'(grant_idx), 128'(1));
    chk("single oreq.addr", 128'(oreq.addr), 128'(32'h40));
    step();
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hDEAD;
    #1;
    chk("single iresps1.data", 128'(iresps[1].data), 128'(32'hDEAD));
    chk("single iresps1.ready", 128'(iresps[1].ready), 128'(1));
    chk("single iresps0", 128'(iresps[0]), 128'(0));
    chk("single iresps2", 128'(iresps[2]), 128'(0));
    step();
    ireqs = '0;
    oresp = '0;
    #1;
    chk("single busy drop", 128'(busy), 128'(0));
    chk("single idle oreq", 128'(oreq), 128'(0));

    // Rotation: all valid, downstream completes every beat immediately.
    pulse_reset();
    for (int i = 0; i < int'(N); i++) ireqs[i].valid = 1'b1;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_busy("rr");
      chk("rr grant_idx", 128'(grant_idx), 128'(exp_rr[k]));
      if (k < 3) begin
        chk("fp busy", 128'(busy_fp), 128'(1));
        chk("fp grant_idx", 128'(grant_idx_fp), 128'(0));
      end
      step();
    end
    ireqs = '0;
    oresp = '0;

    // Four-beat write burst from input 0 while input 1 waits.
    pulse_reset();
    ireqs[0].valid = 1'b1;
    ireqs[0].we    = 1'b1;
    ireqs[0].addr  = 32'h100;
    ireqs[0].strb  = 4'hF;
    ireqs[0].data  = 32'h1000;
    ireqs[1].valid = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      ireqs[0].data = 32'h1000 + 32'(b);
      oresp.ready   = 1'b1;
      oresp.last    = (b == 3);
      #1;
      chk("burst busy", 128'(busy), 128'(1));
      chk("burst grant_idx", 128'(grant_idx), 128'(0));
      chk("burst oreq.data", 128'(oreq.data), 128'(32'h1000 + 32'(b)));
      step();
    end
    ireqs[0] = '0;
    oresp    = '0;
    #1;
    chk("burst idle", 128'(busy), 128'(0));
    step();
    chk("burst next busy", 128'(busy), 128'(1));
    chk("burst next grant_idx", 128'(grant_idx), 128'(1));
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hBEEF;
    #1;
    chk("burst iresps1.data", 128'(iresps[1].data), 128'(32'hBEEF));
    chk("burst iresps0", 128'(iresps[0]), 128'(0));
    step();
    ireqs = '0;
    oresp = '0;

    // Withdrawal: rr_ptr is now 2; input 2 abandons in its second busy cycle.
    ireqs[0].valid = 1'b1;
    ireqs[2].valid = 1'b1;
    step();
    chk("wd grant_idx", 128'(grant_idx), 128'(2));
    step();
    ireqs[2].valid = 1'b0;
    #1;
    chk("wd oreq.valid", 128'(oreq.valid), 128'(0));
    chk("wd still busy", 128'(busy), 128'(1));
    step();
    chk("wd idle", 128'(busy), 128'(0));
    ireqs[2].valid = 1'b1;
    step();
    chk("wd regrant busy", 128'(busy), 128'(1));
    chk("wd regrant grant_idx", 128'(grant_idx), 128'(2));

    // Asynchronous reset between edges during beat 2 of input 2's burst.
    ireqs[2].data = 32'h2222;
    oresp.ready   = 1'b1;
    oresp.last    = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst busy", 128'(busy), 128'(0));
    chk("arst oreq", 128'(oreq), 128'(0));
    chk("arst iresps", 128'(iresps), 128'(0));
    chk("arst grant_idx", 128'(grant_idx), 128'(0));
    oresp = '0;
    #3;
    reset = 1'b1;
    step();
    chk("arst first pick busy", 128'(busy), 128'(1));
    chk("arst first pick grant_idx", 128'(grant_idx), 128'(0));
    ireqs = '0;
    step();

`ifdef CBUS_ARB_PERF_EN
    // Twenty grants to input 0 saturate a 4-bit counter at 15.
    pulse_reset();
    chk("cnt reset", 128'(grant_cnt), 128'(0));
    ireqs[0].valid = 1'b1;
    oresp.ready    = 1'b1;
    oresp.last     = 1'b1;
    for (int g = 0; g < 20; g++) begin
      wait_busy("cnt");
      step();
    end
    ireqs = '0;
    oresp = '0;
    step();
    chk("cnt[0] saturated", 128'(grant_cnt[0]), 128'(4'hF));
    chk("cnt[1]", 128'(grant_cnt[1]), 128'(0));
    chk("cnt[2]", 128'(grant_cnt[2]), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
